adc_trigger_capture: RTL and testbench
======================================

Name: adc_trigger_capture

Overview:
- Sits directly downstream of the ADC1410 wrapper and consumes its two 16-bit channel outputs and its init-done flag.
- Records N = 2^ADDR_SIZE paired samples (ch1/ch2) into a circular buffer around a level/edge trigger, with a programmable pre-trigger depth.
- Holds the capture frozen until a host-side reader drains it sample by sample.

Parameters:
- DATA_SIZE, 16, width of each channel sample (two's complement, signed).
- ADDR_SIZE, 8, buffer address width; depth N = 2^ADDR_SIZE sample pairs.

Ports:
- i_sys_clock  in  1  system clock; one ADC sample per cycle.
- i_reset  in  1  asynchronous, active-high reset.
- i_init_done  in  1  ADC controller initialised; capture allowed only while high.
- i_data_ch1  in  DATA_SIZE  channel 1 sample.
- i_data_ch2  in  DATA_SIZE  channel 2 sample.
- i_arm  in  1  start-capture request; acted on only in IDLE.
- i_trig_src  in  1  trigger source: 0 = ch1, 1 = ch2.
- i_trig_edge  in  1  trigger edge: 0 = rising, 1 = falling.
- i_trig_level  in  DATA_SIZE  signed trigger threshold.
- i_pretrig  in  ADDR_SIZE  number of samples kept before the trigger sample.
- i_force_trig  in  1  software trigger; acted on only in ARMED.
- i_rd_en  in  1  read-one-pair request; acted on only in DONE.
- o_rd_data_ch1  out  DATA_SIZE  read data, channel 1.
- o_rd_data_ch2  out  DATA_SIZE  read data, channel 2.
- o_rd_valid  out  1  read data valid.
- o_armed  out  1  high in the PRE and ARMED states.
- o_triggered  out  1  high in the POST state.
- o_done  out  1  high in the DONE state.

Behaviour:
- Reset values: state IDLE; pointers, counters and prev_valid cleared; all outputs 0.
- Input stage: ch1/ch2 are registered once (s1/s2) every cycle. All writes and trigger comparisons use the registered values. Buffer is a simple dual-port RAM with 1-cycle read latency.
- Pretrig clamp: P = min(i_pretrig, N-1). P is latched when arm is accepted.
- IDLE -> PRE: on i_arm & i_init_done. Write pointer wp cleared; prev_valid cleared.
- PRE:
  - Writes {s1,s2} to wp each cycle, then wp++ (wraps mod N).
  - Stays until P samples are written, then moves to ARMED.
  - If P = 0, goes IDLE -> ARMED directly.
  - Trigger conditions are ignored here.
- ARMED:
  - Writes one pair per cycle and keeps wrapping, so the oldest samples are overwritten.
  - Selected sample x = i_trig_src ? s2 : s1; prev = x from the previous written cycle.
  - Rising trigger: prev_valid & prev < level & x >= level (signed).
  - Falling trigger: prev_valid & prev > level & x <= level (signed).
  - prev_valid sets after the first write since arm.
  - On trigger or i_force_trig: the current sample is written as the trigger sample, trig_addr = wp, and state moves to POST.
- POST: writes exactly N-1-P further pairs, then moves to DONE. If P = N-1, the move to DONE is immediate, next cycle.
- DONE:
  - No writes occur.
  - Read pointer starts at start = (trig_addr - P) mod N.
  - Each i_rd_en reads the next address, wrapping. o_rd_valid and data follow 1 cycle later.
  - After the N-th accepted read, state returns to IDLE in the same cycle that read is issued; the final o_rd_valid still appears the next cycle.
  - i_rd_en outside DONE is ignored (o_rd_valid = 0).
- i_arm outside IDLE is ignored. i_force_trig outside ARMED is ignored.
- i_init_done low in PRE/ARMED/POST aborts to IDLE (capture discarded). In DONE it has no effect.
- Simultaneous level trigger and force in ARMED count as a single trigger.
- Async reset mid-capture or mid-read returns to IDLE immediately. RAM contents are don't-care.
- Ordering guarantee: a drained capture returns samples in chronological order. The trigger sample is read index P (0-based).

Test Plan:
- All scenarios use ADDR_SIZE=4 (N=16), DATA_SIZE=16.
- Ramp ch1 = -100 + 10*k, level=0, rising, src=0, P=4, arm, then read 16 -> trigger sample +0 at read index 4. Reads 0..15 = -40..+110 in steps of 10. o_done drops after the 16th read.
- Ch2 falling ramp 50 -> -100 step -10, level=-5, edge=1, src=1 -> trigger at the first sample <= -5, i.e. -10, at index P. Ch1 reads are captured alongside it unchanged.
- Flat signal, arm, force_trig asserted after 30 ARMED cycles with P=15 -> 15 most recent pre-samples, then the forced sample last (index 15). POST length is 0.
- P=0 with the signal already above level at arm -> no trigger on the first sample (prev_valid=0). A later rising crossing triggers; the trigger sample is read index 0.
- i_init_done dropped in POST -> IDLE next cycle, o_triggered=0. A subsequent arm works normally; i_rd_en in IDLE gives no o_rd_valid.
- i_reset pulse during DONE after 5 reads -> all outputs 0 asynchronously. A new arm/trigger/read sequence returns a full correct 16-sample capture.

Source files
------------

// File: rtl/adc_trigger_capture_if.sv
// Bundle of capture-control, sample and read-back signals between the ADC capture block and its host.
// The slave modport is the capture block and the master modport is the host/ADC side.
interface adc_trigger_capture_if #(
   parameter int DATA_SIZE = 16,
   parameter int ADDR_SIZE = 8
);
   logic                 i_init_done;
   logic [DATA_SIZE-1:0] i_data_ch1;
   logic [DATA_SIZE-1:0] i_data_ch2;
   logic                 i_arm;
   logic                 i_trig_src;
   logic                 i_trig_edge;
   logic [DATA_SIZE-1:0] i_trig_level;
   logic [ADDR_SIZE-1:0] i_pretrig;
   logic                 i_force_trig;
   logic                 i_rd_en;
   logic [DATA_SIZE-1:0] o_rd_data_ch1;
   logic [DATA_SIZE-1:0] o_rd_data_ch2;
   logic                 o_rd_valid;
   logic                 o_armed;
   logic                 o_triggered;
   logic                 o_done;

   modport slave (
      input  i_init_done, i_data_ch1, i_data_ch2, i_arm, i_trig_src, i_trig_edge,
             i_trig_level, i_pretrig, i_force_trig, i_rd_en,
      output o_rd_data_ch1, o_rd_data_ch2, o_rd_valid, o_armed, o_triggered, o_done
   );

   modport master (
      output i_init_done, i_data_ch1, i_data_ch2, i_arm, i_trig_src, i_trig_edge,
             i_trig_level, i_pretrig, i_force_trig, i_rd_en,
      input  o_rd_data_ch1, o_rd_data_ch2, o_rd_valid, o_armed, o_triggered, o_done
   );
endinterface

// File: rtl/adc_trigger_capture.sv
// Captures 2^ADDR_SIZE ch1/ch2 sample pairs around a level/edge trigger into a circular buffer.
// Read data follows i_rd_en by one cycle; no backpressure: the capture stays frozen until fully drained.
module adc_trigger_capture #(
   parameter int DATA_SIZE = 16,
   parameter int ADDR_SIZE = 8
) (
   input  logic                  i_sys_clock,
   input  logic                  i_reset,
   adc_trigger_capture_if.slave  bus
);
   localparam int N = 1 << ADDR_SIZE;

   typedef enum logic [2:0] {IDLE, PRE, ARMED, POST, DONE} state_t;
   state_t state, state_nxt;

   logic signed [DATA_SIZE-1:0] s1, s2, x, prev, level;
   logic [ADDR_SIZE-1:0]        wp, rp, cnt, p_lat, trig_addr, rd_cnt;
   logic                        prev_valid;
   logic [DATA_SIZE-1:0]        mem1 [0:N-1];
   logic [DATA_SIZE-1:0]        mem2 [0:N-1];
   logic [DATA_SIZE-1:0]        rd1, rd2;
   logic                        rd_valid;
   logic                        arm_go, wr_en, trig_go, done_go, rd_go, hit;

   assign x     = bus.i_trig_src ? s2 : s1;
   assign level = bus.i_trig_level;
   assign hit   = bus.i_trig_edge ? (prev_valid && (prev > level) && (x <= level))
                                  : (prev_valid && (prev < level) && (x >= level));

   // i_pretrig is ADDR_SIZE wide, so it can never exceed N-1 and needs no clamp.
   always_comb begin
      state_nxt = state;
      arm_go    = 1'b0;
      wr_en     = 1'b0;
      trig_go   = 1'b0;
      done_go   = 1'b0;
      rd_go     = 1'b0;
      case (state)
         IDLE: begin
            if (bus.i_arm && bus.i_init_done) begin
               arm_go    = 1'b1;
               state_nxt = (bus.i_pretrig == '0) ? ARMED : PRE;
            end
         end
         PRE: begin
            if (!bus.i_init_done) state_nxt = IDLE;
            else begin
               wr_en = 1'b1;
               if (cnt == p_lat - ADDR_SIZE'(1)) state_nxt = ARMED;
            end
         end
         ARMED: begin
            if (!bus.i_init_done) state_nxt = IDLE;
            else begin
               wr_en = 1'b1;
               if (hit || bus.i_force_trig) begin
                  trig_go   = 1'b1;
                  state_nxt = POST;
               end
            end
         end
         POST: begin
            if (!bus.i_init_done) state_nxt = IDLE;
            else if (cnt == '0) begin
               done_go   = 1'b1;
               state_nxt = DONE;
            end else begin
               wr_en = 1'b1;
               if (cnt == ADDR_SIZE'(1)) begin
                  done_go   = 1'b1;
                  state_nxt = DONE;
               end
            end
         end
         DONE: begin
            if (bus.i_rd_en) begin
               rd_go = 1'b1;
               if (rd_cnt == {ADDR_SIZE{1'b1}}) state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge i_sys_clock or posedge i_reset) begin
      if (i_reset) begin
         state      <= IDLE;
         s1         <= '0;
         s2         <= '0;
         wp         <= '0;
         rp         <= '0;
         cnt        <= '0;
         p_lat      <= '0;
         trig_addr  <= '0;
         rd_cnt     <= '0;
         prev       <= '0;
         prev_valid <= 1'b0;
         rd1        <= '0;
         rd2        <= '0;
         rd_valid   <= 1'b0;
      end else begin
         state    <= state_nxt;
         s1       <= bus.i_data_ch1;
         s2       <= bus.i_data_ch2;
         rd_valid <= rd_go;
         if (arm_go) begin
            wp         <= '0;
            cnt        <= '0;
            p_lat      <= bus.i_pretrig;
            prev_valid <= 1'b0;
         end
         if (wr_en) begin
            wp         <= wp + ADDR_SIZE'(1);
            prev       <= x;
            prev_valid <= 1'b1;
         end
         if (state == PRE && wr_en) cnt <= cnt + ADDR_SIZE'(1);
         // Post-trigger count is N-1-P, which is the bitwise complement of P.
         if (trig_go) begin
            trig_addr <= wp;
            cnt       <= ~p_lat;
         end
         if (state == POST && wr_en) cnt <= cnt - ADDR_SIZE'(1);
         if (done_go) begin
            rp     <= trig_addr - p_lat;
            rd_cnt <= '0;
         end
         if (rd_go) begin
            rd1    <= mem1[rp];
            rd2    <= mem2[rp];
            rp     <= rp + ADDR_SIZE'(1);
            rd_cnt <= rd_cnt + ADDR_SIZE'(1);
         end
      end
   end

   always_ff @(posedge i_sys_clock) begin
      if (wr_en) begin
         mem1[wp] <= s1;
         mem2[wp] <= s2;
      end
   end

   assign bus.o_rd_data_ch1 = rd1;
   assign bus.o_rd_data_ch2 = rd2;
   assign bus.o_rd_valid    = rd_valid;
   assign bus.o_armed       = (state == PRE) || (state == ARMED);
   assign bus.o_triggered   = (state == POST);
   assign bus.o_done        = (state == DONE);
endmodule

// File: tb/tb_adc_trigger_capture.sv
// Directed bench for adc_trigger_capture with N=16: table-driven captures plus abort and reset sequences.
module tb_adc_trigger_capture;
   logic clk;
   logic rst;
   int   checks;
   int   errors;

   adc_trigger_capture_if #(.DATA_SIZE(16), .ADDR_SIZE(4)) bus ();

   adc_trigger_capture #(.DATA_SIZE(16), .ADDR_SIZE(4)) dut (
      .i_sys_clock (clk),
      .i_reset     (rst),
      .bus         (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic src;
      logic edg;
      int   level;
      int   pretrig;
      int   c1_start;
      int   c1_step;
      int   c1_turn;
      int   c2_start;
      int   c2_step;
      int   force_k;
      int   e1_first;
      int   e1_step;
      int   e2_first;
      int   e2_step;
   } vec_t;

   vec_t vecs [4];

   task automatic check(input string name, input int idx, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
      end
   endtask

   // ch1 descends for c1_turn samples, then ascends with the same step.
   function automatic int c1_val(input int idx, input int k);
      if (k < vecs[idx].c1_turn) return vecs[idx].c1_start - vecs[idx].c1_step * k;
      return vecs[idx].c1_start + vecs[idx].c1_step * (k - 2 * vecs[idx].c1_turn);
   endfunction

   task automatic capture(input int idx, input bit stop_trig);
      bus.i_trig_src   = vecs[idx].src;
      bus.i_trig_edge  = vecs[idx].edg;
      bus.i_trig_level = 16'(vecs[idx].level);
      bus.i_pretrig    = 4'(vecs[idx].pretrig);
      for (int k = 0; k < 200; k++) begin
         bus.i_data_ch1   = 16'(c1_val(idx, k));
         bus.i_data_ch2   = 16'(vecs[idx].c2_start + vecs[idx].c2_step * k);
         bus.i_arm        = (k == 0);
         bus.i_force_trig = (k == vecs[idx].force_k);
         @(posedge clk); #1;
         if (stop_trig ? bus.o_triggered : bus.o_done) break;
      end
      bus.i_arm        = 1'b0;
      bus.i_force_trig = 1'b0;
      if (stop_trig) check("reach_post", idx, int'(bus.o_triggered), 1);
      else           check("reach_done", idx, int'(bus.o_done), 1);
   endtask

   task automatic drain(input int idx, input int n);
      bus.i_rd_en = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clk); #1;
         if (i == n - 1) bus.i_rd_en = 1'b0;
         check("rd_valid", i, int'(bus.o_rd_valid), 1);
         check("rd_ch1", i, int'($signed(bus.o_rd_data_ch1)), vecs[idx].e1_first + vecs[idx].e1_step * i);
         check("rd_ch2", i, int'($signed(bus.o_rd_data_ch2)), vecs[idx].e2_first + vecs[idx].e2_step * i);
      end
   endtask

   task automatic run_vec(input int idx);
      capture(idx, 1'b0);
      drain(idx, 16);
      check("done_drop", idx, int'(bus.o_done), 0);
      check("idle_armed", idx, int'(bus.o_armed), 0);
      @(posedge clk); #1;
      check("valid_end", idx, int'(bus.o_rd_valid), 0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
      $fatal(1);
   end

   initial begin
      checks = 0;
      errors = 0;
      clk = 1'b0;
      rst = 1'b1;
      bus.i_init_done  = 1'b1;
      bus.i_data_ch1   = '0;
      bus.i_data_ch2   = '0;
      bus.i_arm        = 1'b0;
      bus.i_trig_src   = 1'b0;
      bus.i_trig_edge  = 1'b0;
      bus.i_trig_level = '0;
      bus.i_pretrig    = '0;
      bus.i_force_trig = 1'b0;
      bus.i_rd_en      = 1'b0;

      //          src  edg  lvl  P   c1 start/step/turn  c2 start/step  force  exp ch1     exp ch2
      vecs[0] = '{1'b0, 1'b0,  0,  4, -100,  10, 0, 1000,   1,  -1,  -40,  10, 1006,   1};
      vecs[1] = '{1'b1, 1'b1, -5,  4,   30, -10, 0,   50, -10,  -1,   10, -10,   30, -10};
      vecs[2] = '{1'b0, 1'b0,  0,  0,   30,  10, 4,    0,   1,  -1,    0,  10,    5,   1};
      vecs[3] = '{1'b0, 1'b0,  0, 15,  123,   0, 0,    0,   1,  46,  123,   0,   30,   1};

      #12;
      check("rst_armed", 0, int'(bus.o_armed), 0);
      check("rst_trig", 0, int'(bus.o_triggered), 0);
      check("rst_done", 0, int'(bus.o_done), 0);
      check("rst_valid", 0, int'(bus.o_rd_valid), 0);
      check("rst_data", 0, int'(bus.o_rd_data_ch1), 0);
      @(posedge clk); #1;
      rst = 1'b0;

      // Vector 2 follows vector 1 so a stale, below-level prev is present at its arm.
      for (int v = 0; v < 4; v++) run_vec(v);

      // Abort in POST by dropping init_done, then read attempt in IDLE.
      capture(0, 1'b1);
      bus.i_init_done = 1'b0;
      @(posedge clk); #1;
      check("abort_trig", 0, int'(bus.o_triggered), 0);
      check("abort_armed", 0, int'(bus.o_armed), 0);
      check("abort_done", 0, int'(bus.o_done), 0);
      bus.i_init_done = 1'b1;
      bus.i_rd_en     = 1'b1;
      @(posedge clk); #1;
      bus.i_rd_en = 1'b0;
      check("idle_rd_valid", 0, int'(bus.o_rd_valid), 0);
      run_vec(0);

      // Asynchronous reset during DONE after five reads.
      capture(3, 1'b0);
      drain(3, 5);
      #2;
      rst = 1'b1;
      #1;
      check("arst_valid", 3, int'(bus.o_rd_valid), 0);
      check("arst_ch1", 3, int'(bus.o_rd_data_ch1), 0);
      check("arst_ch2", 3, int'(bus.o_rd_data_ch2), 0);
      check("arst_done", 3, int'(bus.o_done), 0);
      @(posedge clk); #1;
      rst = 1'b0;
      run_vec(1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
